// File: rtl/dcache_wt_pkg.sv
// Shared definitions for the write-through direct-mapped data cache:
// request encodings, default geometry, address field positions and FSM states.
package dcache_wt_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int LINES   = 64;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = 7;
    localparam int TAG_LSB = 8;
    localparam int TAG_MSB = 31;

    typedef enum logic [1:0] {
        RWE_IDLE  = 2'b00,
        RWE_READ  = 2'b01,
        RWE_WRITE = 2'b10
    } rwe_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/data arrays for one-word lines: one asynchronous read port,
// one byte-enabled write port that also marks the line valid, and a valid clear.
module dcache_line_store
    import dcache_wt_pkg::*;
#(
    parameter int LINES_P  = 64,
    parameter int TAG_W_P  = 24,
    parameter int DATA_W_P = 32,
    localparam int IDX_W   = $clog2(LINES_P),
    localparam int BE_W    = DATA_W_P / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic                rd_valid_o,
    output logic [TAG_W_P-1:0]  rd_tag_o,
    output logic [DATA_W_P-1:0] rd_data_o,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [TAG_W_P-1:0]  wr_tag_i,
    input  logic [DATA_W_P-1:0] wr_data_i,
    input  logic [BE_W-1:0]     wr_be_i,
    input  logic                clr_i,
    input  logic [IDX_W-1:0]    clr_idx_i
);

    logic [LINES_P-1:0]  valid_q;
    logic [TAG_W_P-1:0]  tag_q  [LINES_P];
    logic [DATA_W_P-1:0] data_q [LINES_P];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Valid bits: cleared by reset, set on any line write, cleared by invalidate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= {LINES_P{1'b0}};
        end else begin
            if (we_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
            if (clr_i) begin
                valid_q[clr_idx_i] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; validity gates their use.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wt.sv
// Write-through, no-write-allocate, direct-mapped data cache with one-word lines
// and a busy/done handshake towards memory; invalidates take priority in IDLE.
module dcache_wt
    import dcache_wt_pkg::*;
#(
    parameter int LINES  = dcache_wt_pkg::LINES,
    parameter int ADDR_W = dcache_wt_pkg::ADDR_W,
    parameter int DATA_W = dcache_wt_pkg::DATA_W,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        dcache_rwe,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_w_data,
    input  logic [BE_W-1:0]   dcache_sel,
    output logic [DATA_W-1:0] dcache_r_data,
    output logic              dcache_busy,
    output logic              dcache_done,
    input  logic              dcache_flush_flag,
    input  logic [ADDR_W-1:0] dcache_flush_addr,
    output logic [1:0]        mem_rw_flag,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [BE_W-1:0]   mem_write_mask,
    input  logic              mem_busy,
    input  logic              mem_done
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LO  = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LO;

    state_e              state_q, state_d;
    logic [1:0]          flag_q, flag_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mwdata_q, mwdata_d;
    logic [BE_W-1:0]     mmask_q, mmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [IDX_W-1:0]    req_idx_s, flush_idx_s, rd_idx_s;
    logic [TAG_W-1:0]    req_tag_s, flush_tag_s, rd_tag_s;
    logic                rd_valid_s, req_hit_s, flush_hit_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                st_we_s, st_clr_s;
    logic [DATA_W-1:0]   st_wdata_s;
    logic [BE_W-1:0]     st_be_s;
    logic [ADDR_W-1:0]   word_addr_s;
    logic                unused_s;

    assign req_idx_s   = dcache_addr[TAG_LO-1:IDX_LSB];
    assign req_tag_s   = dcache_addr[ADDR_W-1:TAG_LO];
    assign flush_idx_s = dcache_flush_addr[TAG_LO-1:IDX_LSB];
    assign flush_tag_s = dcache_flush_addr[ADDR_W-1:TAG_LO];
    assign word_addr_s = {dcache_addr[ADDR_W-1:IDX_LSB], 2'b00};
    assign req_hit_s   = rd_valid_s && (rd_tag_s == req_tag_s);
    assign flush_hit_s = rd_valid_s && (rd_tag_s == flush_tag_s);
    assign unused_s    = ^{dcache_addr[IDX_LSB-1:0], dcache_flush_addr[IDX_LSB-1:0]};

    dcache_line_store #(
        .LINES_P  (LINES),
        .TAG_W_P  (TAG_W),
        .DATA_W_P (DATA_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx_s),
        .rd_valid_o (rd_valid_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .we_i       (st_we_s),
        .wr_idx_i   (req_idx_s),
        .wr_tag_i   (req_tag_s),
        .wr_data_i  (st_wdata_s),
        .wr_be_i    (st_be_s),
        .clr_i      (st_clr_s),
        .clr_idx_i  (flush_idx_s)
    );

    // Next-state, memory request registers and line-store control.
    always_comb begin
        state_d    = state_q;
        flag_d     = flag_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        mmask_d    = mmask_q;
        rdata_d    = rdata_q;
        rd_idx_s   = req_idx_s;
        st_we_s    = 1'b0;
        st_clr_s   = 1'b0;
        st_wdata_s = dcache_w_data;
        st_be_s    = {BE_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (dcache_flush_flag) begin
                    // The single read port is borrowed for the invalidate tag check.
                    rd_idx_s = flush_idx_s;
                    st_clr_s = flush_hit_s;
                end else if (dcache_rwe[1]) begin
                    state_d = ST_WR_REQ;
                    if (req_hit_s) begin
                        st_we_s = 1'b1;
                        st_be_s = dcache_sel;
                    end else begin
                        st_we_s = 1'b0;
                    end
                end else if (dcache_rwe == RWE_READ) begin
                    if (req_hit_s) begin
                        rdata_d = rd_data_s;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (!mem_busy) begin
                    flag_d  = RWE_READ;
                    maddr_d = word_addr_s;
                    state_d = ST_RD_WAIT;
                end else begin
                    flag_d  = RWE_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (mem_done) begin
                    flag_d     = RWE_IDLE;
                    st_we_s    = 1'b1;
                    st_wdata_s = mem_read_data;
                    st_be_s    = {BE_W{1'b1}};
                    rdata_d    = mem_read_data;
                    state_d    = ST_RESP;
                end else begin
                    state_d    = ST_RD_WAIT;
                end
            end
            ST_WR_REQ: begin
                if (!mem_busy) begin
                    flag_d   = RWE_WRITE;
                    maddr_d  = word_addr_s;
                    mwdata_d = dcache_w_data;
                    mmask_d  = dcache_sel;
                    state_d  = ST_WR_WAIT;
                end else begin
                    flag_d   = RWE_IDLE;
                end
            end
            ST_WR_WAIT: begin
                if (mem_done) begin
                    flag_d  = RWE_IDLE;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WR_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                flag_d  = RWE_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT) ||
                 (state_d == ST_WR_REQ) || (state_d == ST_WR_WAIT);
        done_d = (state_d == ST_RESP);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            flag_q   <= RWE_IDLE;
            maddr_q  <= {ADDR_W{1'b0}};
            mwdata_q <= {DATA_W{1'b0}};
            mmask_q  <= {BE_W{1'b0}};
            rdata_q  <= {DATA_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mmask_q  <= mmask_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mem_rw_flag    = flag_q;
    assign mem_addr       = maddr_q;
    assign mem_write_data = mwdata_q;
    assign mem_write_mask = mmask_q;
    assign dcache_r_data  = rdata_q;
    assign dcache_busy    = busy_q;
    assign dcache_done    = done_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_dcache_wt;

    logic        clk;
    logic        rst;
    logic [1:0]  dcache_rwe;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_w_data;
    logic [3:0]  dcache_sel;
    logic [31:0] dcache_r_data;
    logic        dcache_busy;
    logic        dcache_done;
    logic        dcache_flush_flag;
    logic [31:0] dcache_flush_addr;
    logic [1:0]  mem_rw_flag;
    logic [31:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic        mem_busy;
    logic        mem_done;

    int vectors     = 0;
    int miscompares = 0;

    dcache_wt dut (
        .clk               (clk),
        .rst               (rst),
        .dcache_rwe        (dcache_rwe),
        .dcache_addr       (dcache_addr),
        .dcache_w_data     (dcache_w_data),
        .dcache_sel        (dcache_sel),
        .dcache_r_data     (dcache_r_data),
        .dcache_busy       (dcache_busy),
        .dcache_done       (dcache_done),
        .dcache_flush_flag (dcache_flush_flag),
        .dcache_flush_addr (dcache_flush_addr),
        .mem_rw_flag       (mem_rw_flag),
        .mem_addr          (mem_addr),
        .mem_read_data     (mem_read_data),
        .mem_write_data    (mem_write_data),
        .mem_write_mask    (mem_write_mask),
        .mem_busy          (mem_busy),
        .mem_done          (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic busy, input logic done, input logic [1:0] flag);
        chk({tag, "_busy"}, {31'd0, dcache_busy}, {31'd0, busy});
        chk({tag, "_done"}, {31'd0, dcache_done}, {31'd0, done});
        chk({tag, "_flag"}, {30'd0, mem_rw_flag}, {30'd0, flag});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0; dcache_rwe = 2'b00; dcache_addr = 32'd0; dcache_w_data = 32'd0;
        dcache_sel = 4'b0000; dcache_flush_flag = 1'b0; dcache_flush_addr = 32'd0;
        mem_read_data = 32'd0; mem_busy = 1'b0; mem_done = 1'b0;
        step(); step();
        chk_ctl("reset", 1'b0, 1'b0, 2'b00);
        chk("reset_maddr", mem_addr, 32'd0);
        chk("reset_wdata", mem_write_data, 32'd0);
        chk("reset_mask", {28'd0, mem_write_mask}, 32'd0);
        chk("reset_rdata", dcache_r_data, 32'd0);
        rst = 1'b1;

        // Cold read miss of 0x104, memory answers three cycles after the request.
        dcache_rwe = 2'b01; dcache_addr = 32'h0000_0104;
        step(); chk_ctl("rmiss_acc", 1'b1, 1'b0, 2'b00);
        step(); chk_ctl("rmiss_req", 1'b1, 1'b0, 2'b01);
        chk("rmiss_maddr", mem_addr, 32'h0000_0104);
        step(); chk_ctl("rmiss_w1", 1'b1, 1'b0, 2'b01);
        step(); chk_ctl("rmiss_w2", 1'b1, 1'b0, 2'b01);
        mem_done = 1'b1; mem_read_data = 32'hDEAD_BEEF;
        step(); chk_ctl("rmiss_resp", 1'b0, 1'b1, 2'b00);
        chk("rmiss_rdata", dcache_r_data, 32'hDEAD_BEEF);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step(); chk_ctl("rmiss_idle", 1'b0, 1'b0, 2'b00);

        // Repeat read hits with one-cycle latency.
        dcache_rwe = 2'b01;
        step(); chk_ctl("rhit", 1'b0, 1'b1, 2'b00);
        chk("rhit_rdata", dcache_r_data, 32'hDEAD_BEEF);
        dcache_rwe = 2'b00;
        step(); chk_ctl("rhit_idle", 1'b0, 1'b0, 2'b00);

        // Write hit of the low half-word.
        dcache_rwe = 2'b10; dcache_w_data = 32'h1234_5678; dcache_sel = 4'b0011;
        step(); chk_ctl("whit_acc", 1'b1, 1'b0, 2'b00);
        step(); chk_ctl("whit_req", 1'b1, 1'b0, 2'b10);
        chk("whit_maddr", mem_addr, 32'h0000_0104);
        chk("whit_wdata", mem_write_data, 32'h1234_5678);
        chk("whit_mask", {28'd0, mem_write_mask}, 32'h0000_0003);
        mem_done = 1'b1;
        step(); chk_ctl("whit_resp", 1'b0, 1'b1, 2'b00);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step();
        dcache_rwe = 2'b01;
        step(); chk_ctl("whit_rd", 1'b0, 1'b1, 2'b00);
        chk("whit_rdata", dcache_r_data, 32'hDEAD_5678);
        dcache_rwe = 2'b00;
        step();

        // Write miss to 0x204 using rwe=11; line 1 must keep the 0x104 tag.
        dcache_rwe = 2'b11; dcache_addr = 32'h0000_0204; dcache_w_data = 32'hAAAA_5555;
        dcache_sel = 4'b1111;
        step(); chk_ctl("wmiss_acc", 1'b1, 1'b0, 2'b00);
        step(); chk_ctl("wmiss_req", 1'b1, 1'b0, 2'b10);
        chk("wmiss_maddr", mem_addr, 32'h0000_0204);
        chk("wmiss_mask", {28'd0, mem_write_mask}, 32'h0000_000F);
        mem_done = 1'b1;
        step(); chk_ctl("wmiss_resp", 1'b0, 1'b1, 2'b00);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step();
        dcache_rwe = 2'b01; dcache_addr = 32'h0000_0104;
        step(); chk_ctl("wmiss_keep", 1'b0, 1'b1, 2'b00);
        chk("wmiss_keep_rdata", dcache_r_data, 32'hDEAD_5678);
        dcache_rwe = 2'b00;
        step();

        // Read of 0x204 misses; memory busy for four RD_REQ cycles.
        dcache_rwe = 2'b01; dcache_addr = 32'h0000_0204; mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk_ctl("mbusy_hold", 1'b1, 1'b0, 2'b00);
        end
        mem_busy = 1'b0;
        step(); chk_ctl("mbusy_req", 1'b1, 1'b0, 2'b01);
        chk("mbusy_maddr", mem_addr, 32'h0000_0204);
        mem_done = 1'b1; mem_read_data = 32'hAAAA_5555;
        step(); chk_ctl("mbusy_resp", 1'b0, 1'b1, 2'b00);
        chk("mbusy_rdata", dcache_r_data, 32'hAAAA_5555);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step();

        // Flush with a mismatching tag still takes the cycle but keeps the line.
        dcache_rwe = 2'b01; dcache_flush_flag = 1'b1; dcache_flush_addr = 32'h0000_0104;
        step(); chk_ctl("fmis_cyc", 1'b0, 1'b0, 2'b00);
        dcache_flush_flag = 1'b0;
        step(); chk_ctl("fmis_hit", 1'b0, 1'b1, 2'b00);
        chk("fmis_rdata", dcache_r_data, 32'hAAAA_5555);
        dcache_rwe = 2'b00;
        step();

        // Flush of 0x204 coinciding with its read: invalidate first, then a miss.
        dcache_rwe = 2'b01; dcache_flush_flag = 1'b1; dcache_flush_addr = 32'h0000_0204;
        step(); chk_ctl("flush_cyc", 1'b0, 1'b0, 2'b00);
        dcache_flush_flag = 1'b0;
        step(); chk_ctl("flush_miss", 1'b1, 1'b0, 2'b00);
        step(); chk_ctl("flush_req", 1'b1, 1'b0, 2'b01);
        chk("flush_maddr", mem_addr, 32'h0000_0204);
        mem_done = 1'b1; mem_read_data = 32'h0BAD_F00D;
        step(); chk_ctl("flush_resp", 1'b0, 1'b1, 2'b00);
        chk("flush_rdata", dcache_r_data, 32'h0BAD_F00D);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step();

        // Reset during RD_WAIT; the late mem_done must be ignored.
        dcache_rwe = 2'b01; dcache_addr = 32'h0000_0304;
        step(); step(); chk_ctl("rst_wait", 1'b1, 1'b0, 2'b01);
        rst = 1'b0;
        step(); chk_ctl("rst_mid", 1'b0, 1'b0, 2'b00);
        chk("rst_mid_maddr", mem_addr, 32'd0);
        chk("rst_mid_wdata", mem_write_data, 32'd0);
        chk("rst_mid_rdata", dcache_r_data, 32'd0);
        rst = 1'b1; dcache_rwe = 2'b00; mem_done = 1'b1; mem_read_data = 32'h5555_5555;
        step(); chk_ctl("late_done", 1'b0, 1'b0, 2'b00);
        chk("late_rdata", dcache_r_data, 32'd0);
        mem_done = 1'b0;
        dcache_rwe = 2'b01;
        step(); chk_ctl("no_install", 1'b1, 1'b0, 2'b00);
        step(); chk_ctl("refetch_req", 1'b1, 1'b0, 2'b01);
        mem_done = 1'b1; mem_read_data = 32'h3131_3131;
        step(); chk_ctl("refetch_resp", 1'b0, 1'b1, 2'b00);
        chk("refetch_rdata", dcache_r_data, 32'h3131_3131);
        mem_done = 1'b0; dcache_rwe = 2'b00;
        step(); chk_ctl("final_idle", 1'b0, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 SHALL have clock and reset as: clk  in  1  system clock; rst  in  1  reset, one clock domain, synchronous, active-low (rst=0 resets on the clk rising edge).
REQ-002 SHALL have parameters: LINES, default 64, number of one-word direct-mapped lines; ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-003 SHALL have CPU-side ports:
- dcache_rwe  in  2  request: 01=read, 10=write, 00=idle.
- dcache_addr  in  32  byte address.
- dcache_w_data  in  32  store data.
- dcache_sel  in  4  byte enables.
- dcache_r_data  out  32  load data.
- dcache_busy  out  1  miss or write in progress.
- dcache_done  out  1  one-cycle completion pulse.
- dcache_flush_flag  in  1  invalidate request.
- dcache_flush_addr  in  32  invalidate address.
REQ-004 SHALL have memory-side ports:
- mem_rw_flag  out  2  01=read, 10=write.
- mem_addr  out  32  word-aligned address.
- mem_read_data  in  32  read data.
- mem_write_data  out  32  write data.
- mem_write_mask  out  4  byte mask.
- mem_busy  in  1  memory cannot accept a request.
- mem_done  in  1  one-cycle completion pulse.

Function
REQ-005 SHALL decode the address as: index = addr[7:2], tag = addr[31:8], addr[1:0] ignored; hit = valid[index] and stored tag equal to the request tag.
REQ-006 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
REQ-007 SHALL sample requests only in IDLE; the CPU holds dcache_rwe, dcache_addr, dcache_w_data and dcache_sel stable until dcache_done is returned.
REQ-008 Read hit SHALL give IDLE->RESP, with dcache_r_data equal to the line data and dcache_done=1 in the next cycle (latency 1), and dcache_busy staying 0.
REQ-009 Read miss SHALL give IDLE->RD_REQ; in RD_REQ, while mem_busy=1, SHALL hold mem_rw_flag=00; when mem_busy=0, SHALL drive mem_rw_flag=01 and mem_addr={addr[31:2],2'b00}, then go to RD_WAIT.
REQ-010 In RD_WAIT, SHALL hold mem_rw_flag and mem_addr stable until mem_done=1; on that cycle SHALL write valid, tag and data into the line, capture mem_read_data into dcache_r_data, then go to RESP.
REQ-011 Writes SHALL be write-through and no-write-allocate:
- IDLE->WR_REQ.
- On a hit, the line bytes selected by dcache_sel SHALL update in the acceptance cycle.
- On a miss, no line SHALL change.
REQ-012 WR_REQ/WR_WAIT SHALL follow the same busy/done handshake as reads, with mem_rw_flag=10, mem_write_data=dcache_w_data and mem_write_mask=dcache_sel held until mem_done.
REQ-013 RESP SHALL pulse dcache_done for exactly one cycle, then return to IDLE.
REQ-014 dcache_busy SHALL be 1 in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT, and 0 in IDLE and RESP.
REQ-015 mem_rw_flag SHALL return to 00 in the cycle after mem_done is sampled.
REQ-016 mem_done seen outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-017 A dcache_flush_flag=1 sampled in IDLE SHALL clear valid[flush index] when the tags match, in one cycle, with no memory access and no dcache_done.
REQ-018 When a flush and a CPU request coincide in IDLE, the flush SHALL win; the request SHALL be accepted on the following cycle.
REQ-019 A flush arriving outside IDLE SHALL be ignored; the requester holds it until dcache_busy=0.
REQ-020 dcache_rwe=11 SHALL be treated as a write.
REQ-021 A read following a write to the same address SHALL return the written bytes, whether from a hit-updated line or from memory.

Reset
REQ-022 While rst=0 at a clk edge, the block SHALL apply all of the following:
- state=IDLE.
- All valid bits cleared; tag and data storage need no reset.
- mem_rw_flag=00; mem_addr, mem_write_data and mem_write_mask = 0.
- dcache_r_data=0, dcache_busy=0, dcache_done=0.
REQ-023 Reset during RD_WAIT/WR_WAIT SHALL abandon the transaction; a later mem_done for it SHALL be ignored and SHALL NOT install a line.

Structure
REQ-024 The shared defines file SHALL hold the rwe encodings (read/write/idle), ADDR_W, DATA_W, the index/tag bit positions and the FSM state encodings.
REQ-025 Tag, valid and data storage SHALL be one sub-module, dcache_line_store, with one read port, one write port, byte-enable write and a per-line valid clear; the FSM stays in dcache_wt.

Verification
REQ-026 Cold read miss: read 0x0000_0104, mem returns 0xDEADBEEF after 3 cycles -> mem_rw_flag=01, mem_addr=0x104, dcache_done one cycle after RESP entry, r_data=0xDEADBEEF; a repeat read hits in 1 cycle with no mem access.
REQ-027 Write hit with sel=0011, data 0x1234_5678 to 0x104 -> memory write with mask 0011; a following read hits and returns 0xDEAD5678.
REQ-028 Write miss to 0x204 -> memory write issued, line 1 keeps tag for 0x104; a read of 0x204 then misses.
REQ-029 mem_busy=1 for 4 cycles during RD_REQ -> mem_rw_flag stays 00 until busy drops; dcache_busy=1 throughout.
REQ-030 Flush of 0x104 coinciding with a read of 0x104 -> line invalidated first; the read then misses and fetches from memory.
REQ-031 rst=0 asserted in RD_WAIT, then mem_done after release -> no line installed, no dcache_done, state IDLE.
